alu_arbiter: RTL and testbench

//  Shares one 64-bit ALU (FS[4:2]=op, FS[1:0]=invert {B,A}; status {Z,N,C,V}) between two requesters.

---
 rtl/alu_arbiter.sv | 110 +++++++++++
 tb/tb_alu_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters, with registered
// operands/results and per-requester valid/ready handshakes and completion counters.
module alu_arbiter #(
  parameter int WIDTH     = 64,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [9:0]             req_fs,
  input  logic [2*WIDTH-1:0]     req_a,
  input  logic [2*WIDTH-1:0]     req_b,
  input  logic [1:0]             req_cin,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic [WIDTH-1:0]       rsp_data,
  output logic [3:0]             rsp_status,
  output logic                   rsp_cout,
  output logic [4:0]             alu_fs,
  output logic [WIDTH-1:0]       alu_a,
  output logic [WIDTH-1:0]       alu_b,
  output logic                   alu_cin,
  input  logic [WIDTH-1:0]       alu_f,
  input  logic                   alu_cout,
  input  logic [3:0]             alu_status,
  output logic [2*CNT_WIDTH-1:0] ops_done
);

  // state | meaning
  // IDLE  | arbitrating, req_ready driven to the winner
  // EXEC  | operands held on alu_*, result captured at the end of the cycle
  // RESP  | result presented to the owner until it takes it
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t               state, state_nxt;
  logic                 last_grant;
  logic                 owner;
  logic                 grant_any;
  logic                 grant_idx;
  logic                 rsp_ack;
  logic [CNT_WIDTH-1:0] cnt0, cnt1;

  assign grant_any = |req_valid;
  // On a tie the requester that did not win last time gets the ALU.
  assign grant_idx = (&req_valid) ? ~last_grant : req_valid[1];
  assign rsp_ack   = rsp_ready[owner];
  assign ops_done  = {cnt1, cnt0};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && grant_any) req_ready = grant_idx ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      alu_fs     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cin    <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 2'b00;
      rsp_data   <= '0;
      rsp_status <= '0;
      rsp_cout   <= 1'b0;
      cnt0       <= '0;
      cnt1       <= '0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          alu_fs     <= grant_idx ? req_fs[9:5] : req_fs[4:0];
          alu_a      <= grant_idx ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
          alu_b      <= grant_idx ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
          alu_cin    <= grant_idx ? req_cin[1] : req_cin[0];
          owner      <= grant_idx;
          last_grant <= grant_idx;
        end
        EXEC: begin
          rsp_data   <= alu_f;
          rsp_status <= alu_status;
          rsp_cout   <= alu_cout;
          rsp_valid  <= owner ? 2'b10 : 2'b01;
        end
        RESP: if (rsp_ack) begin
          rsp_valid <= 2'b00;
          if (owner) cnt1 <= cnt1 + 1'b1;
          else       cnt0 <= cnt0 + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a reference ALU stub feeds the DUT, expected responses
// are queued at acceptance and checked when the owner sees rsp_valid.
module tb_alu_arbiter;
  localparam int W  = 64;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [1:0]    req_valid, req_ready, req_cin, rsp_valid, rsp_ready;
  logic [9:0]    req_fs;
  logic [2*W-1:0] req_a, req_b;
  logic [W-1:0]  rsp_data, alu_a, alu_b, alu_f;
  logic [3:0]    rsp_status, alu_status;
  logic          rsp_cout, alu_cin, alu_cout;
  logic [4:0]    alu_fs;
  logic [2*CW-1:0] ops_done;

  always #5 clock = ~clock;

  alu_arbiter #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_fs(req_fs),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_status(rsp_status), .rsp_cout(rsp_cout),
    .alu_fs(alu_fs), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout), .alu_status(alu_status),
    .ops_done(ops_done)
  );

  // Reference ALU: returns {f, {Z,N,C,V}, cout}
  function automatic logic [68:0] alu_model(logic [4:0] fs, logic [63:0] a, logic [63:0] b,
                                            logic cin);
    logic [63:0] aa, bb, f;
    logic [64:0] s;
    logic        c, v;
    aa = fs[0] ? ~a : a;
    bb = fs[1] ? ~b : b;
    c  = 1'b0;
    v  = 1'b0;
    s  = '0;
    case (fs[4:2])
      3'd0: f = aa & bb;
      3'd1: f = aa | bb;
      3'd2: begin
        s = {1'b0, aa} + {1'b0, bb} + {64'd0, cin};
        f = s[63:0];
        c = s[64];
        v = (aa[63] == bb[63]) && (f[63] != aa[63]);
      end
      3'd3: f = aa ^ bb;
      3'd4: f = aa;
      3'd5: f = bb;
      default: f = '0;
    endcase
    return {f, (f == 64'd0), f[63], c, v, c};
  endfunction

  assign {alu_f, alu_status, alu_cout} = alu_model(alu_fs, alu_a, alu_b, alu_cin);

  typedef struct {
    logic [4:0]  fs;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
  } op_t;

  typedef struct {
    int          owner;
    logic [63:0] f;
    logic [3:0]  st;
    logic        co;
    op_t         op;
    int          acc;
  } exp_t;

  op_t   q0[$], q1[$];
  exp_t  sb[$];
  int    grants[$];
  logic [1:0]    rr;
  logic [1:0]    s_ready, s_rspv;
  logic [CW-1:0] cnt_m [2];
  logic          lg_m;
  bit            chk_exec, lat_done;
  int            cyc;
  int            vectors    = 0;
  int            miscompares = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    req_valid = {q1.size() != 0, q0.size() != 0};
    if (q0.size() != 0) begin
      req_fs[4:0] = q0[0].fs; req_a[63:0] = q0[0].a; req_b[63:0] = q0[0].b; req_cin[0] = q0[0].cin;
    end
    if (q1.size() != 0) begin
      req_fs[9:5] = q1[0].fs; req_a[127:64] = q1[0].a; req_b[127:64] = q1[0].b; req_cin[1] = q1[0].cin;
    end
    rsp_ready = rr;
  endtask

  function automatic op_t mk(logic [4:0] fs, logic [63:0] a, logic [63:0] b, logic cin);
    op_t o;
    o.fs = fs; o.a = a; o.b = b; o.cin = cin;
    return o;
  endfunction

  function automatic op_t rnd_op();
    return mk(5'($urandom_range(0, 31)), {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
  endfunction

  // One clock: sample at negedge, update models, then step past the rising edge.
  task automatic cycle();
    logic [1:0] exp_ready;
    logic [68:0] r;
    exp_t e;
    int i;
    @(negedge clock);
    s_ready = req_ready;
    s_rspv  = rsp_valid;
    chk("ready_and_rspv", 128'(req_ready & rsp_valid), 128'(0));
    chk("ops_done", 128'(ops_done), 128'({cnt_m[1], cnt_m[0]}));
    if (sb.size() != 0 || req_valid == 2'b00) exp_ready = 2'b00;
    else if (req_valid == 2'b11)              exp_ready = lg_m ? 2'b01 : 2'b10;
    else                                      exp_ready = req_valid;
    chk("req_ready", 128'(req_ready), 128'(exp_ready));
    if (chk_exec) begin
      e = sb[$];
      chk("alu_operands", {55'(alu_fs), alu_cin, alu_a}, {55'(e.op.fs), e.op.cin, e.op.a});
      chk("alu_b", 128'(alu_b), 128'(e.op.b));
      chk_exec = 0;
    end
    if (rsp_valid != 2'b00) begin
      if (sb.size() == 0) chk("unexpected_rsp", 128'(rsp_valid), 128'(0));
      else begin
        chk("rsp_owner", 128'(rsp_valid), 128'(sb[0].owner != 0 ? 2'b10 : 2'b01));
        if (!lat_done) begin
          chk("latency", 128'(cyc - sb[0].acc), 128'(2));
          lat_done = 1;
        end
        chk("rsp_result", {59'(rsp_data), rsp_status, rsp_cout},
            {59'(sb[0].f), sb[0].st, sb[0].co});
        if (rsp_ready[sb[0].owner]) begin
          cnt_m[sb[0].owner] = cnt_m[sb[0].owner] + 1'b1;
          void'(sb.pop_front());
          lat_done = 0;
        end
      end
    end
    if ((req_ready & req_valid) != 2'b00) begin
      i = req_ready[1] ? 1 : 0;
      e.op = (i == 1) ? q1[0] : q0[0];
      r = alu_model(e.op.fs, e.op.a, e.op.b, e.op.cin);
      e.owner = i; e.f = r[68:5]; e.st = r[4:1]; e.co = r[0]; e.acc = cyc;
      sb.push_back(e);
      grants.push_back(i);
      lg_m = 1'(i);
      chk_exec = 1;
      if (i == 1) void'(q1.pop_front());
      else        void'(q0.pop_front());
    end
    @(posedge clock);
    #1;
    cyc++;
    drive();
  endtask

  task automatic run_idle();
    for (int k = 0; k < 300; k++) begin
      if (q0.size() == 0 && q1.size() == 0 && sb.size() == 0) break;
      cycle();
    end
    chk("drain", 128'(q0.size() + q1.size() + sb.size()), 128'(0));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_handshake", 128'({req_ready, rsp_valid}), 128'(0));
    chk("rst_rsp", {59'(rsp_data), rsp_status, rsp_cout}, 128'(0));
    chk("rst_alu", {55'(alu_fs), alu_cin, alu_a}, 128'(0));
    chk("rst_alu_b_cnt", {56'(ops_done), alu_b}, 128'(0));
    sb.delete();
    chk_exec = 0; lat_done = 0;
    cnt_m[0] = '0; cnt_m[1] = '0;
    lg_m = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    drive();
  endtask

  initial begin
    req_fs = '0; req_a = '0; req_b = '0; req_cin = '0;
    rr = 2'b11; cyc = 0;
    drive();
    do_reset();

    // op code 6 passes through, ALU returns zero
    q0.push_back(mk(5'b11000, 64'hDEAD_BEEF, 64'h1, 1'b1));
    drive(); run_idle();
    chk("op6_result", {59'(rsp_data), rsp_status, rsp_cout}, {59'(0), 4'b1000, 1'b0});

    // subtract to zero on requester 1
    q1.push_back(mk(5'b01010, 64'h1234, 64'h1234, 1'b1));
    drive(); run_idle();
    chk("sub_zero", {59'(rsp_data), rsp_status, rsp_cout}, {59'(0), 4'b1010, 1'b1});

    // single add on requester 0
    q0.push_back(mk(5'b01000, 64'h5, 64'h3, 1'b0));
    drive(); run_idle();
    chk("add", {59'(rsp_data), rsp_status, rsp_cout}, {59'(64'h8), 4'b0000, 1'b0});
    chk("add_cnt", 128'(ops_done), 128'({4'd1, 4'd2}));

    // reset while an operation is in EXEC
    q0.push_back(mk(5'b01000, 64'h10, 64'h20, 1'b0));
    drive();
    for (int k = 0; k < 5 && !chk_exec; k++) cycle();
    do_reset();

    // contention after reset: requester 0 must win first, then alternate
    grants.delete();
    q0.push_back(rnd_op()); q0.push_back(rnd_op());
    q1.push_back(rnd_op()); q1.push_back(rnd_op());
    drive(); run_idle();
    chk("grant_order", 128'({grants.size() == 4 ? {grants[0][1:0], grants[1][1:0], grants[2][1:0],
        grants[3][1:0]} : 8'hFF}), 128'(8'b00_01_00_01));

    // backpressure on requester 0 with requester 1 waiting
    rr = 2'b10;
    q0.push_back(rnd_op());
    drive();
    for (int k = 0; k < 6 && s_rspv[0] !== 1'b1; k++) cycle();
    q1.push_back(rnd_op());
    drive();
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("bp_ready1", 128'(s_ready[1]), 128'(0));
    end
    rr = 2'b11;
    drive();
    cycle();
    cycle();
    chk("bp_grant1", 128'(s_ready), 128'(2'b10));
    run_idle();

    // overflow, then counter wrap on requester 0
    do_reset();
    q0.push_back(mk(5'b01000, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0));
    drive(); run_idle();
    chk("overflow", {59'(rsp_data), rsp_status, rsp_cout},
        {59'(64'h8000_0000_0000_0000), 4'b0101, 1'b0});
    for (int k = 0; k < 14; k++) q0.push_back(rnd_op());
    drive(); run_idle();
    chk("cnt_15", 128'(ops_done), 128'({4'd0, 4'd15}));
    q0.push_back(rnd_op());
    drive(); run_idle();
    chk("cnt_wrap", 128'(ops_done), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "timeout");
  end
endmodule
